hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Sequences the IF/ID pipeline register, PC load and ID/EX bubble insertion for the ARM-subset pipeline.
- Detects load-use hazards on the instruction in ID and flushes wrong-path fetches after a taken branch.
- Freezes the whole pipeline while data memory is busy, and keeps saturating stall/flush performance counters.
- IF/ID "hold" is achieved by holding the PC with IFID_LE kept at 1, so IF/ID reloads the same instruction. IF/ID treats LE=0 as clear, so IFID_LE is never used to hold.

Parameters:
FLUSH_CYCLES, 1, number of consecutive IF/ID flush cycles after a taken branch (1..15)
CNT_W, 16, width of the performance counters

Ports:
CLK  input  1  clock
CLR  input  1  reset, synchronous, active-high
ID_Rn  input  4  Rn field of the instruction in ID
ID_Rm  input  4  Rm field of the instruction in ID
ID_Uses_Rn  input  1  ID instruction reads Rn
ID_Uses_Rm  input  1  ID instruction reads Rm
IDEX_Load  input  1  instruction in EX is a load
IDEX_Rd  input  4  destination register of the instruction in EX
Branch_Taken  input  1  taken branch resolved in ID this cycle
Mem_Busy  input  1  data memory has not completed its access
PC_LE  output  1  PC load enable
IFID_LE  output  1  IF/ID load enable (0 clears IF/ID)
IFID_CLR  output  1  IF/ID clear (flush)
IDEX_Bubble  output  1  select NOP control word into ID/EX
Pipe_Freeze  output  1  hold ID/EX, EX/MEM and MEM/WB registers
State_Out  output  2  current state: 0 RUN, 1 FLUSH, 2 MEM_WAIT
Stall_Count  output  CNT_W  cycles with PC_LE=0 outside reset, saturating
Flush_Count  output  CNT_W  taken-branch events, saturating

Behaviour:
- Only State, flush_cnt and the two counters are registered. Control outputs are combinational from state and inputs, valid the same cycle.
- CLR high, sampled on the CLK edge: state=RUN, flush_cnt=0, both counters=0.
- While CLR is high, outputs are forced: PC_LE=0, IFID_LE=1, IFID_CLR=1, IDEX_Bubble=1, Pipe_Freeze=0.
- Stall_Count does not count cycles with CLR high.
- CLR asserted mid-FLUSH or mid-MEM_WAIT aborts that state immediately.
- hazard = IDEX_Load & ((ID_Uses_Rn & ID_Rn==IDEX_Rd) | (ID_Uses_Rm & ID_Rm==IDEX_Rd)).
- Priority: Mem_Busy > hazard > Branch_Taken.
- RUN, default: PC_LE=1, IFID_LE=1, IFID_CLR=0, IDEX_Bubble=0, Pipe_Freeze=0.
- RUN, Mem_Busy=1: PC_LE=0, Pipe_Freeze=1, IDEX_Bubble=0; next state MEM_WAIT. Branch_Taken and hazard are ignored this cycle (ID is held and re-evaluated later).
- RUN, hazard=1:
  - PC_LE=0, IDEX_Bubble=1; Branch_Taken is ignored, since the ID instruction will be re-presented.
  - Stall lasts exactly 1 cycle, because the load advances to MEM (forwarding covers the rest).
- RUN, Branch_Taken=1:
  - PC_LE=1 (target loads), IFID_CLR=1; Flush_Count increments.
  - If FLUSH_CYCLES>1: flush_cnt=FLUSH_CYCLES-1, next state FLUSH. Otherwise stay in RUN.
- FLUSH:
  - PC_LE=1, IFID_CLR=1, IDEX_Bubble=1; Branch_Taken and hazard are ignored.
  - flush_cnt decrements; the cycle with flush_cnt==1 returns to RUN.
  - Mem_Busy=1 takes precedence: freeze outputs apply and next state is MEM_WAIT; flush_cnt is kept and FLUSH resumes after MEM_WAIT.
- MEM_WAIT:
  - PC_LE=0, Pipe_Freeze=1, IFID_CLR=0.
  - Stays while Mem_Busy=1. On Mem_Busy=0, apply RUN decode this cycle (or FLUSH decode if flush_cnt!=0) and take that state's transition.
- Counters saturate at all-ones and do not wrap.
- Stall_Count increments on every cycle with PC_LE=0 and CLR=0.

Decomposition:
- Shared pipeline package holds the state encoding constants (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2) and the NOP control-word constant used with IDEX_Bubble.
- One sub-module, sat_counter (parameter W, inc, CLR): instantiated twice for Stall_Count and Flush_Count.

Test Plan:
- Reset: CLR=1 for 2 cycles with Mem_Busy=1 -> PC_LE=0, IFID_CLR=1, State_Out=0, counters 0. After release with quiet inputs -> PC_LE=1, IFID_CLR=0.
- Load-use: IDEX_Load=1, IDEX_Rd=3, ID_Uses_Rm=1, ID_Rm=3 for one cycle -> PC_LE=0 and IDEX_Bubble=1 for 1 cycle, Stall_Count=1. Same with ID_Uses_Rm=0 -> no stall.
- Branch, FLUSH_CYCLES=3: Branch_Taken pulse -> IFID_CLR=1 for 3 consecutive cycles, State_Out 0,1,1,0, Flush_Count=1, PC_LE=1 throughout.
- Memory wait: Mem_Busy=1 for 4 cycles with Branch_Taken=1 and hazard=1 -> Pipe_Freeze=1 and PC_LE=0 for 4 cycles. On the 5th cycle hazard is taken first (bubble), then the branch. Stall_Count=5.
- Flush interrupted: Mem_Busy rises in the 2nd FLUSH cycle (FLUSH_CYCLES=3) for 2 cycles -> MEM_WAIT for 2 cycles, then 1 remaining FLUSH cycle with IFID_CLR=1.
- Saturation, CNT_W=4: hold Mem_Busy=1 for 20 cycles -> Stall_Count stops at 15. Then CLR mid-MEM_WAIT -> State_Out=0 and counter 0 on the next edge.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding, the NOP control
// word selected into ID/EX on a bubble, and the load-use compare.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hcu_state_t;

    // Control word muxed into ID/EX when IDEX_Bubble is asserted (all
    // write/memory enables low).
    localparam logic [15:0] NOP_CTRL_WORD = '0;

    // True when the ID instruction reads the register a load in EX will write.
    function automatic logic load_use(
        input logic       idex_load,
        input logic [3:0] idex_rd,
        input logic       uses_rn,
        input logic [3:0] rn,
        input logic       uses_rm,
        input logic [3:0] rm
    );
        return idex_load & ((uses_rn & (rn == idex_rd)) | (uses_rm & (rm == idex_rd)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side connection of the hazard control unit: ID/EX hazard inputs,
// branch/memory status, and the pipeline register controls it produces.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ID_Rn;
    logic [3:0]       ID_Rm;
    logic             ID_Uses_Rn;
    logic             ID_Uses_Rm;
    logic             IDEX_Load;
    logic [3:0]       IDEX_Rd;
    logic             Branch_Taken;
    logic             Mem_Busy;
    logic             PC_LE;
    logic             IFID_LE;
    logic             IFID_CLR;
    logic             IDEX_Bubble;
    logic             Pipe_Freeze;
    logic [1:0]       State_Out;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output ID_Rn, ID_Rm, ID_Uses_Rn, ID_Uses_Rm, IDEX_Load, IDEX_Rd,
               Branch_Taken, Mem_Busy,
        input  PC_LE, IFID_LE, IFID_CLR, IDEX_Bubble, Pipe_Freeze, State_Out,
               Stall_Count, Flush_Count
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_Uses_Rn, ID_Uses_Rm, IDEX_Load, IDEX_Rd,
               Branch_Taken, Mem_Busy,
        output PC_LE, IFID_LE, IFID_CLR, IDEX_Bubble, Pipe_Freeze, State_Out,
               Stall_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at the maximum, clear synchronously.
    always_ff @(posedge CLK) begin
        if (CLR)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control for the ARM-subset pipeline: load-use stalls, taken-branch
// flushes, memory-busy freeze, plus stall/flush performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  CLR,
    hazard_control_unit_if.slave  bus
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    hcu_state_t       state, state_nxt;
    logic [3:0]       flush_cnt, flush_nxt;
    logic             hazard;
    logic             pc_le, ifid_clr, bubble, freeze, flush_evt;
    logic [CNT_W-1:0] stall_count, flush_count;

    assign hazard = load_use(bus.IDEX_Load, bus.IDEX_Rd, bus.ID_Uses_Rn, bus.ID_Rn,
                             bus.ID_Uses_Rm, bus.ID_Rm);

    // State and remaining-flush register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    // Next-state and control decode. Mem_Busy is tested first for every state,
    // so MEM_WAIT with Mem_Busy=0 falls through to the FLUSH or RUN decode.
    always_comb begin
        pc_le     = 1'b1;
        ifid_clr  = 1'b0;
        bubble    = 1'b0;
        freeze    = 1'b0;
        flush_evt = 1'b0;
        state_nxt = state;
        flush_nxt = flush_cnt;
        if (CLR) begin
            pc_le     = 1'b0;
            ifid_clr  = 1'b1;
            bubble    = 1'b1;
            state_nxt = RUN;
            flush_nxt = '0;
        end else if (bus.Mem_Busy) begin
            pc_le     = 1'b0;
            freeze    = 1'b1;
            state_nxt = MEM_WAIT;
        end else if ((state == FLUSH) || ((state == MEM_WAIT) && (flush_cnt != '0))) begin
            ifid_clr  = 1'b1;
            bubble    = 1'b1;
            flush_nxt = flush_cnt - 1'b1;
            state_nxt = (flush_cnt == 4'd1) ? RUN : FLUSH;
        end else if (hazard) begin
            pc_le     = 1'b0;
            bubble    = 1'b1;
            state_nxt = RUN;
        end else if (bus.Branch_Taken) begin
            ifid_clr  = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                flush_nxt = FLUSH_INIT;
                state_nxt = FLUSH;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            state_nxt = RUN;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .CLR   (CLR),
        .inc   (~pc_le & ~CLR),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .CLR   (CLR),
        .inc   (flush_evt),
        .count (flush_count)
    );

    assign bus.PC_LE       = pc_le;
    assign bus.IFID_LE     = 1'b1;
    assign bus.IFID_CLR    = ifid_clr;
    assign bus.IDEX_Bubble = bubble;
    assign bus.Pipe_Freeze = freeze;
    assign bus.State_Out   = state;
    assign bus.Stall_Count = stall_count;
    assign bus.Flush_Count = flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal checks plus
// randomized traffic, all compared each cycle against a behavioural model.
module tb_hazard_control_unit;

    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    hazard_control_unit_if #(.CNT_W(CW)) bus ();

    hazard_control_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Model: flush cycles still owed, whether the pipe is parked on memory,
    // and the two event tallies.
    int m_owed    = 0;
    bit m_parked  = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int model_state();
        if (m_parked) return 2;
        if (m_owed > 0) return 1;
        return 0;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge CLK) begin
        bit hz;
        int e_pc, e_clr, e_bub, e_frz;
        bit took_branch;
        hz = bus.IDEX_Load && ((bus.ID_Uses_Rn && bus.ID_Rn == bus.IDEX_Rd) ||
                               (bus.ID_Uses_Rm && bus.ID_Rm == bus.IDEX_Rd));
        chk("State_Out", int'(bus.State_Out), model_state());
        chk("Stall_Count", int'(bus.Stall_Count), m_stalls);
        chk("Flush_Count", int'(bus.Flush_Count), m_flushes);
        took_branch = 1'b0;
        e_pc = 1; e_clr = 0; e_bub = 0; e_frz = 0;
        if (CLR) begin
            e_pc = 0; e_clr = 1; e_bub = 1;
        end else if (bus.Mem_Busy) begin
            e_pc = 0; e_frz = 1;
        end else if (m_owed > 0) begin
            e_clr = 1; e_bub = 1;
        end else if (hz) begin
            e_pc = 0; e_bub = 1;
        end else if (bus.Branch_Taken) begin
            e_clr = 1; took_branch = 1'b1;
        end
        chk("PC_LE", int'(bus.PC_LE), e_pc);
        chk("IFID_LE", int'(bus.IFID_LE), 1);
        chk("IFID_CLR", int'(bus.IFID_CLR), e_clr);
        chk("IDEX_Bubble", int'(bus.IDEX_Bubble), e_bub);
        chk("Pipe_Freeze", int'(bus.Pipe_Freeze), e_frz);
        if (CLR) begin
            m_owed = 0; m_parked = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e_pc == 0 && m_stalls < CMAX) m_stalls++;
            if (bus.Mem_Busy) begin
                m_parked = 1'b1;
            end else begin
                m_parked = 1'b0;
                if (m_owed > 0) m_owed--;
                else if (took_branch) begin
                    m_owed = FC - 1;
                    if (m_flushes < CMAX) m_flushes++;
                end
            end
        end
    end

    // Apply one cycle of inputs just after the clock edge, return at negedge.
    task automatic step(input bit clr, input bit busy, input bit br, input bit ld,
                        input int rd, input bit urn, input int rn, input bit urm, input int rm);
        @(posedge CLK);
        #1;
        CLR              = clr;
        bus.Mem_Busy     = busy;
        bus.Branch_Taken = br;
        bus.IDEX_Load    = ld;
        bus.IDEX_Rd      = 4'(rd);
        bus.ID_Uses_Rn   = urn;
        bus.ID_Rn        = 4'(rn);
        bus.ID_Uses_Rm   = urm;
        bus.ID_Rm        = 4'(rm);
        @(negedge CLK);
    endtask

    task automatic quiet();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.Mem_Busy = 1'b1; bus.Branch_Taken = 1'b0; bus.IDEX_Load = 1'b0;
        bus.IDEX_Rd = '0; bus.ID_Uses_Rn = 1'b0; bus.ID_Rn = '0;
        bus.ID_Uses_Rm = 1'b0; bus.ID_Rm = '0;

        // Reset with memory busy: forced outputs, counters clear.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("rst PC_LE", int'(bus.PC_LE), 0);
            chk("rst IFID_CLR", int'(bus.IFID_CLR), 1);
            chk("rst State", int'(bus.State_Out), 0);
            chk("rst Stall_Count", int'(bus.Stall_Count), 0);
        end
        quiet();
        chk("run PC_LE", int'(bus.PC_LE), 1);
        chk("run IFID_CLR", int'(bus.IFID_CLR), 0);

        // Load-use on Rm, then the same without Rm in use.
        step(0, 0, 0, 1, 3, 0, 0, 1, 3);
        chk("lu PC_LE", int'(bus.PC_LE), 0);
        chk("lu Bubble", int'(bus.IDEX_Bubble), 1);
        quiet();
        chk("lu release PC_LE", int'(bus.PC_LE), 1);
        chk("lu Stall_Count", int'(bus.Stall_Count), 1);
        step(0, 0, 0, 1, 3, 0, 0, 0, 3);
        chk("nolu PC_LE", int'(bus.PC_LE), 1);
        chk("nolu Bubble", int'(bus.IDEX_Bubble), 0);

        // Taken branch: three flush cycles, states 0,1,1 then back to 0.
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("br0 IFID_CLR", int'(bus.IFID_CLR), 1);
        chk("br0 State", int'(bus.State_Out), 0);
        quiet();
        chk("br1 IFID_CLR", int'(bus.IFID_CLR), 1);
        chk("br1 State", int'(bus.State_Out), 1);
        chk("br1 PC_LE", int'(bus.PC_LE), 1);
        chk("br1 Flush_Count", int'(bus.Flush_Count), 1);
        quiet();
        chk("br2 IFID_CLR", int'(bus.IFID_CLR), 1);
        chk("br2 State", int'(bus.State_Out), 1);
        quiet();
        chk("br3 IFID_CLR", int'(bus.IFID_CLR), 0);
        chk("br3 State", int'(bus.State_Out), 0);

        // Memory wait masking a hazard and a branch, then hazard before branch.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 5, 1, 5, 0, 0);
            chk("mw Freeze", int'(bus.Pipe_Freeze), 1);
            chk("mw PC_LE", int'(bus.PC_LE), 0);
        end
        step(0, 0, 1, 1, 5, 1, 5, 0, 0);
        chk("mw hz PC_LE", int'(bus.PC_LE), 0);
        chk("mw hz Bubble", int'(bus.IDEX_Bubble), 1);
        chk("mw hz IFID_CLR", int'(bus.IFID_CLR), 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mw br IFID_CLR", int'(bus.IFID_CLR), 1);
        chk("mw br PC_LE", int'(bus.PC_LE), 1);
        chk("mw Stall_Count", int'(bus.Stall_Count), 5);
        quiet();
        quiet();

        // Flush interrupted by memory busy, then the remaining flush cycle.
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        quiet();
        chk("fi1 State", int'(bus.State_Out), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("fi2 IFID_CLR", int'(bus.IFID_CLR), 0);
        chk("fi2 Freeze", int'(bus.Pipe_Freeze), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("fi3 State", int'(bus.State_Out), 2);
        quiet();
        chk("fi4 State", int'(bus.State_Out), 2);
        chk("fi4 IFID_CLR", int'(bus.IFID_CLR), 1);
        chk("fi4 PC_LE", int'(bus.PC_LE), 1);
        quiet();
        chk("fi5 State", int'(bus.State_Out), 0);
        chk("fi5 IFID_CLR", int'(bus.IFID_CLR), 0);

        // Saturation under a long memory wait, then reset mid-wait.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("sat Stall_Count", int'(bus.Stall_Count), 15);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("clrmw Freeze", int'(bus.Pipe_Freeze), 0);
        quiet();
        chk("clrmw State", int'(bus.State_Out), 0);
        chk("clrmw Stall_Count", int'(bus.Stall_Count), 0);

        // Randomized traffic with occasional busy bursts and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 50),
                 int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)));
        end

        quiet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
